// File: rtl/kmi_tx_ctrl.sv
// KMI transmit feeder: queues bytes from the register block and launches one
// Transmit frame per byte, with completion wait, inter-frame gap and timeout.
module kmi_tx_ctrl #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned GAP_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input  logic                     ref_clk,
    input  logic                     nreset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     err_clr,
    input  logic                     tx_done,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    output logic                     busy,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf_err,
    output logic                     tmo_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            tx_done_q;

    logic            done_rise;
    logic            pop;
    logic            push;
    logic            ovf_evt;
    logic            tmo_evt;
    logic [LW-1:0]   level_nxt;

    // Queue bookkeeping; a pop in the same cycle frees the slot a full-FIFO write needs.
    always_comb begin
        done_rise = tx_done & ~tx_done_q;
        pop       = (state == IDLE) && !fifo_empty && !flush;
        push      = wr_en && !flush && (!fifo_full || pop);
        ovf_evt   = wr_en && !flush && fifo_full && !pop;
        tmo_evt   = (state == WAIT) && !done_rise && (tmo_cnt == TW'(TIMEOUT_CYCLES - 2));
        level_nxt = fifo_level;
        if (flush) begin
            level_nxt = '0;
        end else begin
            level_nxt = LW'(fifo_level + LW'(push) - LW'(pop));
        end
    end

    always_ff @(posedge ref_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge ref_clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            tx_done_q  <= 1'b0;
            ovf_err    <= 1'b0;
            tmo_err    <= 1'b0;
        end else begin
            tx_done_q  <= tx_done;
            fifo_level <= level_nxt;
            fifo_empty <= (level_nxt == '0);
            fifo_full  <= (level_nxt == LW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= PW'(wr_ptr + PW'(1));
                if (pop)  rd_ptr <= PW'(rd_ptr + PW'(1));
            end
            // A same-cycle error event beats the clear strobe.
            ovf_err <= ovf_evt | (ovf_err & ~err_clr);
            tmo_err <= tmo_evt | (tmo_err & ~err_clr);
        end
    end

    // Frame sequencing; tx_data only changes on a pop, so it is held through GAP.
    always_ff @(posedge ref_clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            tx_data  <= '0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (done_rise || tmo_evt) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        tmo_cnt <= TW'(tmo_cnt + TW'(1));
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= GW'(gap_cnt + GW'(1));
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
